// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the clk_div_gen slice.
//   clk_div_state_t : controller states (IDLE, DELAY, RUN, DRAIN)
//   clk_div_cfg_t   : clamped period/high/phase triple (32-bit fields)
//   clk_div_clamp() : clamps a raw (P, H, D) triple to its legal ranges
// Optional feature macro used by the top: CLK_DIV_PERIOD_CNT_EN.
package clk_div_pkg;

  localparam int CLK_DIV_CNT_W = 16;

  localparam logic [31:0] CLK_DIV_RST_P = 32'd2;
  localparam logic [31:0] CLK_DIV_RST_H = 32'd1;
  localparam logic [31:0] CLK_DIV_RST_D = 32'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } clk_div_state_t;

  typedef struct packed {
    logic [31:0] p;
    logic [31:0] h;
    logic [31:0] d;
  } clk_div_cfg_t;

  // P >= 2, 1 <= H <= P-1, D <= P-1.
  function automatic clk_div_cfg_t clk_div_clamp(input logic [31:0] p,
                                                 input logic [31:0] h,
                                                 input logic [31:0] d);
    clk_div_cfg_t c;
    c.p = (p < 32'd2) ? 32'd2 : p;
    if (h == 32'd0)               c.h = 32'd1;
    else if (h > (c.p - 32'd1))   c.h = c.p - 32'd1;
    else                          c.h = h;
    c.d = (d > (c.p - 32'd1)) ? (c.p - 32'd1) : d;
    return c;
  endfunction

endpackage

// File: rtl/clk_div_cfg_shadow.sv
// clk_div_cfg_shadow: shadow and active configuration registers.
//   load_i captures clamped period/high/phase into the shadow set.
//   Active set follows shadow every cycle while idle_i is high, otherwise
//   only on boundary_i (last cycle of a period), so a period is never cut.
//   A load coincident with a boundary goes straight into the active set.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   load_i, period_i, high_i, phase_i raw configuration strobe and fields
//   idle_i, boundary_i                update qualifiers from the controller
//   act_per_o, act_high_o, act_phase_o active (clamped) configuration
module clk_div_cfg_shadow
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CLK_DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] high_i,
  input  logic [CNT_W-1:0] phase_i,
  input  logic             idle_i,
  input  logic             boundary_i,
  output logic [CNT_W-1:0] act_per_o,
  output logic [CNT_W-1:0] act_high_o,
  output logic [CNT_W-1:0] act_phase_o
);

  clk_div_cfg_t     cap;
  logic             unused_cap_par;
  logic [CNT_W-1:0] cap_per, cap_high, cap_phase;
  logic [CNT_W-1:0] sh_per_q, sh_high_q, sh_phase_q;
  logic [CNT_W-1:0] sh_per_d, sh_high_d, sh_phase_d;
  logic [CNT_W-1:0] act_per_q, act_high_q, act_phase_q;
  logic [CNT_W-1:0] act_per_d, act_high_d, act_phase_d;

  always_comb begin
    cap       = clk_div_clamp(32'(period_i), 32'(high_i), 32'(phase_i));
    cap_per   = cap.p[CNT_W-1:0];
    cap_high  = cap.h[CNT_W-1:0];
    cap_phase = cap.d[CNT_W-1:0];
  end

  // Clamped values never exceed the input width; upper bits are always zero.
  assign unused_cap_par = ^cap;

  always_comb begin
    sh_per_d    = sh_per_q;
    sh_high_d   = sh_high_q;
    sh_phase_d  = sh_phase_q;
    act_per_d   = act_per_q;
    act_high_d  = act_high_q;
    act_phase_d = act_phase_q;
    if (load_i) begin
      sh_per_d   = cap_per;
      sh_high_d  = cap_high;
      sh_phase_d = cap_phase;
    end
    if (idle_i) begin
      act_per_d   = sh_per_q;
      act_high_d  = sh_high_q;
      act_phase_d = sh_phase_q;
    end else if (boundary_i) begin
      act_per_d   = load_i ? cap_per   : sh_per_q;
      act_high_d  = load_i ? cap_high  : sh_high_q;
      act_phase_d = load_i ? cap_phase : sh_phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_per_q    <= CNT_W'(CLK_DIV_RST_P);
      sh_high_q   <= CNT_W'(CLK_DIV_RST_H);
      sh_phase_q  <= CNT_W'(CLK_DIV_RST_D);
      act_per_q   <= CNT_W'(CLK_DIV_RST_P);
      act_high_q  <= CNT_W'(CLK_DIV_RST_H);
      act_phase_q <= CNT_W'(CLK_DIV_RST_D);
    end else begin
      sh_per_q    <= sh_per_d;
      sh_high_q   <= sh_high_d;
      sh_phase_q  <= sh_phase_d;
      act_per_q   <= act_per_d;
      act_high_q  <= act_high_d;
      act_phase_q <= act_phase_d;
    end
  end

  assign act_per_o   = act_per_q;
  assign act_high_o  = act_high_q;
  assign act_phase_o = act_phase_q;

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: programmable clock-pattern generator on the system clock.
// Produces div_clk with programmable period P, high time H and start
// delay D (all in clk cycles). Stopping always completes the current period.
// div_clk is a clock-enable / pattern source, not a clock tree root.
//
// state | meaning
// IDLE  | stopped, outputs low, active config tracks shadow
// DELAY | counting the start delay D, div_clk held low
// RUN   | generating periods, enable high
// DRAIN | enable seen low, finishing the current period
//
// Ports:
//   clk, rst_n                  system clock, async active-low reset
//   enable                      run request (level)
//   period, high_time, phase    raw configuration, captured by load
//   load                        one-cycle configuration strobe
//   div_clk, running            registered outputs
//   period_tick                 high in the last cycle of each period
//   period_cnt (optional)       completed periods, saturating; present only
//                               when CLK_DIV_PERIOD_CNT_EN is defined
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CLK_DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_time,
  input  logic [CNT_W-1:0] phase,
  input  logic             load,
  output logic             div_clk,
  output logic             running,
  output logic             period_tick
`ifdef CLK_DIV_PERIOD_CNT_EN
  ,
  output logic [31:0]      period_cnt
`endif
);

  clk_div_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             div_q, div_d;
  logic             run_q, run_d;

  logic [CNT_W-1:0] act_per, act_high, act_phase;
  logic [CNT_W-1:0] cnt_next;
  logic             last_cnt, in_period, tick;

  clk_div_cfg_shadow #(.CNT_W(CNT_W)) u_cfg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .period_i    (period),
    .high_i      (high_time),
    .phase_i     (phase),
    .idle_i      (state_q == IDLE),
    .boundary_i  (tick),
    .act_per_o   (act_per),
    .act_high_o  (act_high),
    .act_phase_o (act_phase)
  );

  assign last_cnt  = (cnt_q == (act_per - CNT_W'(1)));
  assign in_period = (state_q == RUN) || (state_q == DRAIN);
  assign tick      = in_period && last_cnt;
  assign cnt_next  = last_cnt ? '0 : (cnt_q + CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    div_d   = div_q;
    case (state_q)
      IDLE: begin
        div_d = 1'b0;
        if (enable) begin
          if (act_phase == '0) begin
            state_d = RUN;
            cnt_d   = '0;
            div_d   = 1'b1;
          end else begin
            state_d = DELAY;
            dcnt_d  = CNT_W'(1);
          end
        end
      end
      DELAY: begin
        div_d = 1'b0;
        if (!enable) begin
          state_d = IDLE;
        end else if (dcnt_q == act_phase) begin
          state_d = RUN;
          cnt_d   = '0;
          div_d   = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      RUN, DRAIN: begin
        // Enable low on the last cycle ends the run at this wrap, whether the
        // drop was seen earlier (DRAIN) or only now (RUN).
        if (!enable && last_cnt) begin
          state_d = IDLE;
          cnt_d   = '0;
          div_d   = 1'b0;
        end else begin
          state_d = enable ? RUN : DRAIN;
          cnt_d   = cnt_next;
          div_d   = (cnt_next < act_high);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        div_d   = 1'b0;
      end
    endcase
    run_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      div_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      div_q   <= div_d;
      run_q   <= run_d;
    end
  end

  assign div_clk     = div_q;
  assign running     = run_q;
  assign period_tick = tick;

`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [31:0] pcnt_q, pcnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    if ((state_q == IDLE) && enable) begin
      pcnt_d = '0;
    end else if (tick && (pcnt_q != 32'hFFFF_FFFF)) begin
      pcnt_d = pcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt_q <= '0;
    else        pcnt_q <= pcnt_d;
  end

  assign period_cnt = pcnt_q;
`endif

endmodule
